uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers. Accepts bytes over per-requester valid/ready handshakes and sequences the transmitter's start/data_in/tx_busy interface one frame at a time. Sits between the client logic and the UART transmitter. Includes a start-acknowledge watchdog and a programmable inter-frame gap.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width, matches transmitter data_in
ACK_TIMEOUT, 4096, clk cycles allowed between tx_start rise and tx_busy rise
GAP_CYCLES, 0, idle clk cycles inserted after tx_busy falls before the next grant

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse to the granted requester
tx_start  out  1  to transmitter start
tx_data  out  DATA_WIDTH  to transmitter data_in, held stable for the whole frame
tx_busy  in  1  from transmitter
grant_id  out  $clog2(NUM_REQ)  index of the current or last owner
active  out  1  high from byte accept until frame completion, gap included
frame_done  out  1  1-cycle pulse on detected tx_busy falling edge
timeout_err  out  1  sticky, set on watchdog expiry, cleared only by reset

Behaviour:
- Reset values (rst_n=1): state IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, frame_done=0, timeout_err=0, round-robin pointer=0, counters=0. Reset is asynchronous. Release takes effect at the next clk edge.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req_valid, choose the winner round-robin starting at pointer. Same cycle: assert req_ready[winner]=1, register req_data slice into tx_data, set grant_id=winner, set pointer=winner+1 mod NUM_REQ. Next state LAUNCH. Otherwise stay in IDLE.
- Accept cost is 1 cycle. A requester's valid may drop only after its ready pulse.
- LAUNCH: tx_start=1, clear watchdog counter. Go to WAIT_BUSY.
- WAIT_BUSY: tx_start stays 1 until tx_busy is sampled 1. Then tx_start=0 and go to WAIT_DONE. The counter increments each cycle.
- Watchdog: if the counter reaches ACK_TIMEOUT-1 without tx_busy, set timeout_err, tx_start=0, frame_done stays 0, and go to IDLE. The byte is dropped.
- WAIT_DONE: register tx_busy. When 1->0 is seen, pulse frame_done. If GAP_CYCLES>0 go to GAP, else go to IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- active=1 in LAUNCH, WAIT_BUSY, WAIT_DONE and GAP.
- Back-to-back minimum from frame_done to the next tx_start is GAP_CYCLES+2 cycles (IDLE accept, then LAUNCH).
- tx_busy already 1 on entry to LAUNCH (stale): treat as acknowledged on the WAIT_BUSY sample. Edge detection in WAIT_DONE still requires the fall.
- Simultaneous valids: strict round-robin. No requester waits more than NUM_REQ-1 grants.
- A requester dropping valid before it is granted is simply skipped.
- Reset asserted mid-frame: all outputs return to reset values immediately. The transmitter frame may be truncated; this is the transmitter's concern.
- The pointer wraps NUM_REQ-1 -> 0. Counters are sized $clog2(max(ACK_TIMEOUT,GAP_CYCLES+1)).

Decomposition:
- Package uart_pkg:
  - arb_state_t enum: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP
  - DATA_WIDTH default constant
  - clog2-based width localparams helper
- Sub-module rr_arbiter:
  - Inputs: req vector, pointer
  - Outputs: one-hot grant, index, any_req
  - Combinational, parameterised by NUM_REQ, reusable for a future RX dispatcher

Test Plan:
- Single requester 1, byte 8'hA5, with the real transmitter -> one req_ready[1] pulse; tx_data=8'hA5 held until frame_done; grant_id=1; exactly one frame_done.
- All 4 valid simultaneously with bytes 8'h55, 8'hAA, 8'hFF, 8'h00, pointer 0 -> grant order 0,1,2,3; then requester 0 refilled wins next; tx bytes observed in that order.
- GAP_CYCLES=5 with back-to-back requests -> exactly 7 clk cycles from the frame_done pulse to the next tx_start rise.
- Transmitter stub holds tx_busy=0 for ACK_TIMEOUT=16 cycles -> tx_start drops after 16 cycles; timeout_err=1 and remains 1; the next request is still served normally.
- Reset (rst_n=1) pulsed during WAIT_DONE of byte 8'h3C -> tx_start, active and req_ready read 0 immediately; after release, the first grant goes to requester 0.
- Requester 2 valid only, then requester 2 dropped and requester 3 raised before grant -> requester 3 granted, with no ready pulse on requester 2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit path.
// Imported by the TX arbiter and its round-robin picker.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } arb_state_t;

    localparam int DATA_WIDTH_DEF = 8;

    // Width of an index into n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One counter serves the watchdog and the gap timer.
    function automatic int cnt_width(input int ack, input int gap);
        int m;
        m = (ack > gap + 1) ? ack : gap + 1;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or
// after the pointer, wrapping to index 0.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [idx_width(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [idx_width(NUM_REQ)-1:0] idx,
    output logic                          any_req
);

    localparam int IW = idx_width(NUM_REQ);

    // Scan NUM_REQ slots starting at ptr; the first hit wins.
    always_comb begin
        int          j;
        logic [IW-1:0] k;
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        k       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            k = IW'(j);
            if (!any_req && req[k]) begin
                any_req  = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers,
// one frame at a time, with start watchdog and inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ACK_TIMEOUT = 4096,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          active,
    output logic                          frame_done,
    output logic                          timeout_err
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = cnt_width(ACK_TIMEOUT, GAP_CYCLES);

    // Watchdog fires when the increment would reach ACK_TIMEOUT-1.
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 2);
    localparam logic [CW-1:0] GAP_LAST =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win;
    logic [NUM_REQ-1:0]  grant;
    logic                any_req;
    logic                accept;
    logic                busy_fall;
    logic                wd_expire;
    logic [CW-1:0]       cnt;
    logic                busy_q;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .idx     (win),
        .any_req (any_req)
    );

    assign frame_done = busy_fall;

    // Next state, handshake pulse and transmitter strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy_fall  = 1'b0;
        wd_expire  = 1'b0;
        req_ready  = '0;
        tx_start   = 1'b0;
        active     = 1'b1;
        case (state)
            IDLE: begin
                active = 1'b0;
                if (any_req && !rst_n) begin
                    accept     = 1'b1;
                    req_ready  = grant;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start   = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tx_start = 1'b1;
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == ACK_LAST) begin
                    wd_expire  = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (busy_q && !tx_busy) begin
                    busy_fall  = 1'b1;
                    state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and the shared watchdog / gap counter.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= tx_busy;
            if (state_next != state) begin
                cnt <= '0;
            end else if (state == WAIT_BUSY || state == GAP) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Capture the winner's byte and advance the fairness pointer.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_data     <= '0;
            grant_id    <= '0;
            ptr         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                tx_data  <= req_bytes[win];
                grant_id <= win;
                ptr      <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
            end
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter stub, scoreboard of
// launched bytes, vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NR        = 4;
    localparam int DW        = 8;
    localparam int ACK       = 16;
    localparam int GAPC      = 5;
    localparam int FRAME_LEN = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] b;
    } exp_t;

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  id;
        logic [7:0]  b;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic          active;
    logic          frame_done;
    logic          timeout_err;

    int     errors = 0;
    int     checks = 0;
    exp_t   sb[$];
    logic   start_q = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int     frames = 0;
    int     n_acc = 0;
    logic [3:0] acc = '0;
    logic [3:0] last_acc = '0;
    logic [3:0] ever_ready = '0;
    logic   fd_now = 1'b0;
    logic   rise_now = 1'b0;
    logic   busy_s = 1'b0;
    bit     stub_dead = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .ACK_TIMEOUT (ACK),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    // Transmitter stub: busy for FRAME_LEN cycles after a start.
    initial begin
        int bcnt;
        bcnt    = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bcnt > 0) begin
                bcnt = bcnt - 1;
                if (bcnt == 0) tx_busy = 1'b0;
            end else if (tx_start && !stub_dead) begin
                tx_busy = 1'b1;
                bcnt    = FRAME_LEN;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.b  = b;
        return e;
    endfunction

    // One cycle: sample at negedge, drop accepted valids after the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        fd_now     = frame_done;
        rise_now   = tx_start && !start_q;
        start_q    = tx_start;
        busy_s     = tx_busy;
        ever_ready = ever_ready | req_ready;
        if (rise_now) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_launch: unexpected frame byte 0x%0h", tx_data);
            end else begin
                e = sb.pop_front();
                chk("tx_byte", 32'(tx_data), 32'(e.b));
                chk("tx_owner", 32'(grant_id), 32'(e.id));
            end
            cur_byte = tx_data;
        end
        if (fd_now) begin
            frames++;
            chk("tx_held", 32'(tx_data), 32'(cur_byte));
        end
        acc = req_valid & req_ready;
        if (acc != 0) begin
            last_acc = acc;
            n_acc++;
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic wait_acc(input int max, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (acc != 0) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic run_quiet(input int max, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (req_valid == 0 && !active && !tx_start && !busy_s) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        vec_t vt[8];
        int   f0;
        int   n;
        bit   refilled;
        bit   seen;

        vt[0] = '{4'b0010, 32'h0000_A500, 2'd1, 8'hA5};
        vt[1] = '{4'b0011, 32'h0000_2211, 2'd0, 8'h11};
        vt[2] = '{4'b1001, 32'hC300_0044, 2'd3, 8'hC3};
        vt[3] = '{4'b1001, 32'h6600_0012, 2'd0, 8'h12};
        vt[4] = '{4'b0001, 32'h0000_0034, 2'd0, 8'h34};
        vt[5] = '{4'b1100, 32'h8877_0000, 2'd2, 8'h77};
        vt[6] = '{4'b0101, 32'h00AB_00CD, 2'd0, 8'hCD};
        vt[7] = '{4'b1000, 32'hEF00_0000, 2'd3, 8'hEF};

        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b0;

        foreach (vt[i]) begin
            f0        = frames;
            req_data  = vt[i].data;
            req_valid = vt[i].valid;
            sb.push_back(mk(vt[i].id, vt[i].b));
            wait_acc(30, "vec_accept");
            chk("vec_ready", 32'(last_acc), 32'(4'(1) << vt[i].id));
            chk("vec_grant_id", 32'(grant_id), 32'(vt[i].id));
            req_valid = '0;
            run_quiet(200, "vec_quiet");
            chk("vec_frames", 32'(frames - f0), 32'd1);
        end

        req_data  = 32'h00FF_AA55;
        req_valid = 4'hF;
        sb.push_back(mk(2'd0, 8'h55));
        sb.push_back(mk(2'd1, 8'hAA));
        sb.push_back(mk(2'd2, 8'hFF));
        sb.push_back(mk(2'd3, 8'h00));
        sb.push_back(mk(2'd0, 8'h5A));
        n_acc    = 0;
        refilled = 1'b0;
        seen     = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (acc[0] && !refilled) begin
                req_data[7:0] = 8'h5A;
                req_valid[0]  = 1'b1;
                refilled      = 1'b1;
            end
            if (refilled && req_valid == 0 && !active && !busy_s) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rr_quiet", 32'(seen), 32'd1);
        chk("rr_accepts", 32'(n_acc), 32'd5);
        chk("rr_last", 32'(last_acc), 32'b0001);

        req_data  = 32'h002D_1E00;
        req_valid = 4'b0110;
        sb.push_back(mk(2'd1, 8'h1E));
        sb.push_back(mk(2'd2, 8'h2D));
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (fd_now) begin
                seen = 1'b1;
                break;
            end
        end
        chk("gap_first_done", 32'(seen), 32'd1);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (rise_now) break;
        end
        chk("gap_done_to_start", 32'(n), 32'd7);
        run_quiet(200, "gap_quiet");

        req_data  = 32'h4342_0040;
        req_valid = 4'b0001;
        sb.push_back(mk(2'd0, 8'h40));
        wait_acc(30, "drop_first_accept");
        ever_ready = '0;
        req_valid  = 4'b0100;
        repeat (3) tick();
        req_valid  = 4'b1000;
        sb.push_back(mk(2'd3, 8'h43));
        run_quiet(300, "drop_quiet");
        chk("drop_no_ready2", 32'(ever_ready[2]), 32'd0);
        chk("drop_winner", 32'(last_acc), 32'b1000);

        stub_dead = 1'b1;
        f0        = frames;
        req_data  = 32'h0000_7700;
        req_valid = 4'b0010;
        sb.push_back(mk(2'd1, 8'h77));
        wait_acc(30, "wd_accept");
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (start_q) n++;
            else if (n > 0) break;
        end
        chk("wd_start_len", 32'(n), 32'd16);
        chk("wd_err_set", 32'(timeout_err), 32'd1);
        chk("wd_no_done", 32'(frames - f0), 32'd0);
        stub_dead = 1'b0;
        repeat (3) tick();
        chk("wd_err_sticky", 32'(timeout_err), 32'd1);
        f0        = frames;
        req_data  = 32'h0099_0000;
        req_valid = 4'b0100;
        sb.push_back(mk(2'd2, 8'h99));
        wait_acc(30, "wd_next_accept");
        run_quiet(200, "wd_next_quiet");
        chk("wd_next_frames", 32'(frames - f0), 32'd1);
        chk("wd_err_kept", 32'(timeout_err), 32'd1);

        req_data  = 32'h003C_0000;
        req_valid = 4'b0100;
        sb.push_back(mk(2'd2, 8'h3C));
        wait_acc(30, "mid_accept");
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (busy_s && !start_q && active) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_wait_done", 32'(seen), 32'd1);
        req_data  = 32'hD300_00D0;
        req_valid = 4'b1001;
        rst_n     = 1'b1;
        #1;
        chk("mid_rst_start", 32'(tx_start), 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (!busy_s && k > 1) break;
        end
        rst_n = 1'b0;
        sb.push_back(mk(2'd0, 8'hD0));
        sb.push_back(mk(2'd3, 8'hD3));
        wait_acc(30, "post_rst_accept");
        chk("post_rst_first", 32'(last_acc), 32'b0001);
        run_quiet(300, "post_rst_quiet");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
